// File: rtl/uart_key_pkg.sv
// Shared types and helpers for the UART key lock.
// Parity support is selected by UART_KEY_LOCK_PARITY_EN in the receiver core.
package uart_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    typedef logic [7:0] byte_t;

    function automatic int unsigned mid_count(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchroniser, down-counting bit timer, frame FSM, registered byte and strobes.
// Build option UART_KEY_LOCK_PARITY_EN adds an even-parity bit (8E1); default frame is 8N1.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a low level on rxs
//  START  | start bit; high at mid-bit is a glitch and aborts silently
//  DATA   | eight data bits, LSB first, sampled at mid-bit
//  PARITY | even-parity bit (parity builds only)
//  STOP   | stop bit; high and parity ok -> rx_valid, otherwise rx_err
//  BREAK  | after an error, wait for the line to return high
module uart_rx_core
    import uart_key_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic  clk_12,
    input  logic  rst_n,
    input  logic  uart_rx,
    output byte_t rx_data,
    output logic  rx_valid,
    output logic  rx_err
);
    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID    = CW'(mid_count(CLKS_PER_BIT));

    rx_state_t     state, state_nx;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    byte_t         shift;
    logic          reload, at_mid, at_end, valid_nx, err_nx, par_ok;

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    assign at_mid = (cnt == MID);
    assign at_end = (cnt == '0);

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (reload)  cnt <= RELOAD;
        else if (!at_end) cnt <= cnt - CW'(1);
    end

    always_comb begin
        state_nx = state;
        reload   = 1'b0;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nx = START;
                    reload   = 1'b1;
                end
            end
            START: begin
                if (at_mid && rxs) begin
                    state_nx = IDLE;
                end else if (at_end) begin
                    state_nx = DATA;
                    reload   = 1'b1;
                end
            end
            DATA: begin
                if (at_end) begin
                    reload = 1'b1;
                    if (bitn == 3'd7) begin
`ifdef UART_KEY_LOCK_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_KEY_LOCK_PARITY_EN
            PARITY: begin
                if (at_end) begin
                    state_nx = STOP;
                    reload   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (at_mid) begin
                    if (rxs && par_ok) begin
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bitn     <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_valid <= valid_nx;
            rx_err   <= err_nx;
            if (valid_nx) rx_data <= shift;
            if (state == START)                bitn <= '0;
            else if (state == DATA && at_end)  bitn <= bitn + 3'd1;
            if (state == DATA && at_mid)       shift[bitn] <= rxs;
        end
    end

`ifdef UART_KEY_LOCK_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n)                       par_bit <= 1'b0;
        else if (state == PARITY && at_mid) par_bit <= rxs;
    end

    // even parity: the parity bit equals the XOR of the data bits
    assign par_ok = (par_bit == ^shift);
`else
    assign par_ok = 1'b1;
`endif

endmodule

// File: rtl/uart_key_lock.sv
// UART key lock: received bytes slide through a KEY_BYTES window; open when the window holds KEY.
// UART_KEY_LOCK_PARITY_EN selects 8E1 framing in the receiver core (default 8N1).
module uart_key_lock
    import uart_key_pkg::*;
#(
    parameter int                     CLKS_PER_BIT = 104,
    parameter int                     KEY_BYTES    = 8,
    parameter logic [KEY_BYTES*8-1:0] KEY          = 64'h54504D3231333721
) (
    input  logic  clk_12,
    input  logic  rst_n,
    input  logic  uart_rx,
    input  logic  clear,
    output byte_t rx_data,
    output logic  rx_valid,
    output logic  rx_err,
    output logic  open
);
    localparam int            WW   = KEY_BYTES * 8;
    localparam int            BW   = $clog2(KEY_BYTES + 1);
    localparam logic [BW-1:0] BMAX = BW'(KEY_BYTES);

    logic [WW-1:0] window, window_nx;
    logic [BW-1:0] bcnt, bcnt_nx;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_12  (clk_12),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    assign window_nx = (window << 8) | WW'(rx_data);
    assign bcnt_nx   = (bcnt == BMAX) ? bcnt : bcnt + BW'(1);

    // bcnt gates the compare so a reset or flushed window never matches by accident
    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
            bcnt   <= '0;
            open   <= 1'b0;
        end else if (clear) begin
            window <= '0;
            bcnt   <= '0;
            open   <= 1'b0;
        end else if (rx_valid) begin
            window <= window_nx;
            bcnt   <= bcnt_nx;
            open   <= (window_nx == KEY) && (bcnt_nx == BMAX);
        end else if (rx_err) begin
            bcnt   <= '0;
            open   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_key_lock.sv
// Bench for uart_key_lock: "OK" key, 104 clocks per bit, byte-history reference model.
module tb_uart_key_lock;
    localparam int          CPB   = 104;
    localparam int          KB    = 2;
    localparam logic [15:0] KEY_V = 16'h4F4B;

    logic       clk_12  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       uart_rx = 1'b1;
    logic       clear   = 1'b0;
    logic [7:0] rx_data, rx_data0;
    logic       rx_valid, rx_err, open;
    logic       rx_valid0, rx_err0, open0;

    int         checks  = 0;
    int         errors  = 0;
    int         n_valid = 0;
    int         n_err   = 0;
    logic [7:0] got_q[$];
    logic [7:0] mdl_q[$];
    logic       valid_prev = 1'b0;
    logic       open_after = 1'b0;
`ifdef UART_KEY_LOCK_PARITY_EN
    logic       par_flip   = 1'b0;
`endif

    uart_key_lock #(.CLKS_PER_BIT(CPB), .KEY_BYTES(KB), .KEY(KEY_V)) dut (
        .clk_12(clk_12), .rst_n(rst_n), .uart_rx(uart_rx), .clear(clear),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .open(open)
    );

    uart_key_lock #(.CLKS_PER_BIT(CPB), .KEY_BYTES(KB), .KEY(16'h0000)) dut0 (
        .clk_12(clk_12), .rst_n(rst_n), .uart_rx(uart_rx), .clear(clear),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_err(rx_err0), .open(open0)
    );

    always #5 clk_12 = ~clk_12;

    always @(negedge clk_12) begin
        if (valid_prev) open_after = open;
        valid_prev = rx_valid;
        if (rx_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(rx_data);
        end
        if (rx_err === 1'b1) n_err++;
    end

    // open is expected when the last KB bytes since the last flush spell the key
    function automatic logic model_open();
        if (mdl_q.size() < KB) return 1'b0;
        for (int i = 0; i < KB; i++)
            if (mdl_q[mdl_q.size() - 1 - i] !== KEY_V[8*i +: 8]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] pop_got();
        if (got_q.size() == 0) return 8'hxx;
        return got_q.pop_front();
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        @(negedge clk_12);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk_12);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk_12);
        end
`ifdef UART_KEY_LOCK_PARITY_EN
        uart_rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk_12);
`endif
        uart_rx = stop_b;
        repeat (CPB) @(negedge clk_12);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b1);
        mdl_q.push_back(b);
        repeat (4) @(negedge clk_12);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk_12);
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_err !== 1'b0 || open !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: data=%h valid=%b err=%b open=%b, required 00/0/0/0",
                     rx_data, rx_valid, rx_err, open);
        end
        rst_n = 1'b1;
        n_valid = 0;
        n_err   = 0;
        got_q.delete();
        mdl_q.delete();
        repeat (20) @(negedge clk_12);
        checks++;
        if (n_valid != 0 || n_err != 0 || open !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: valids=%0d errs=%0d open=%b, required 0/0/0", n_valid, n_err, open);
        end
        send_ok(8'h00);
        void'(pop_got());
        checks++;
        if (open0 !== 1'b0) begin
            errors++;
            $display("FAIL key0_bcnt_gate: open0=%b, required 0", open0);
        end
        send_ok(8'h00);
        void'(pop_got());
        checks++;
        if (open0 !== 1'b1) begin
            errors++;
            $display("FAIL key0_full_window: open0=%b, required 1", open0);
        end
    endtask

    task automatic test_unlock();
        logic [7:0] g;
        send_ok(8'h4F);
        g = pop_got();
        checks++;
        if (g !== 8'h4F) begin errors++; $display("FAIL unlock_byte_O: got %h, required 4f", g); end
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL unlock_half: open=%b, required %b", open, model_open()); end
        send_ok(8'h4B);
        g = pop_got();
        checks++;
        if (g !== 8'h4B) begin errors++; $display("FAIL unlock_byte_K: got %h, required 4b", g); end
        checks++;
        if (open_after !== model_open()) begin
            errors++;
            $display("FAIL unlock_timing: open one cycle after rx_valid=%b, required %b", open_after, model_open());
        end
        send_ok(8'h58);
        void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL relock_X: open=%b, required %b", open, model_open()); end
    endtask

    task automatic test_glitch();
        int v0, e0;
        logic [7:0] g;
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk_12);
        uart_rx = 1'b0;
        repeat (30) @(negedge clk_12);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk_12);
        checks++;
        if (n_valid != v0 || n_err != e0) begin
            errors++;
            $display("FAIL glitch_strobes: valids=%0d errs=%0d, required 0/0", n_valid - v0, n_err - e0);
        end
        send_ok(8'h41);
        g = pop_got();
        checks++;
        if (g !== 8'h41) begin errors++; $display("FAIL glitch_next_byte: got %h, required 41", g); end
    endtask

    task automatic test_framing();
        int v0, e0;
        logic [7:0] g;
        send_ok(8'h4F);
        send_ok(8'h4B);
        send_ok(8'h4F);
        repeat (3) void'(pop_got());
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h4B, 1'b0);
        repeat (500) @(negedge clk_12);
        checks++;
        if (n_err - e0 != 1) begin errors++; $display("FAIL framing_err_count: got %0d, required 1", n_err - e0); end
        checks++;
        if (n_valid != v0) begin errors++; $display("FAIL framing_no_valid: got %0d, required 0", n_valid - v0); end
        uart_rx = 1'b1;
        mdl_q.delete();
        repeat (20) @(negedge clk_12);
        send_ok(8'h4B);
        g = pop_got();
        checks++;
        if (g !== 8'h4B) begin errors++; $display("FAIL framing_recover_byte: got %h, required 4b", g); end
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL framing_bcnt_cleared: open=%b, required %b", open, model_open()); end
        send_ok(8'h4F);
        send_ok(8'h4B);
        repeat (2) void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL framing_reopen: open=%b, required %b", open, model_open()); end
        send_frame(8'h00, 1'b0);
        repeat (20) @(negedge clk_12);
        uart_rx = 1'b1;
        mdl_q.delete();
        repeat (20) @(negedge clk_12);
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL err_drops_open: open=%b, required %b", open, model_open()); end
    endtask

    task automatic test_clear();
        logic [7:0] g;
        int t;
        send_ok(8'h4F);
        send_ok(8'h4B);
        repeat (2) void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL clear_pre_open: open=%b, required %b", open, model_open()); end
        t = 0;
        fork
            send_frame(8'h4B, 1'b1);
            begin
                while (rx_valid !== 1'b1 && t < 2000) begin
                    @(negedge clk_12);
                    t++;
                end
                if (rx_valid === 1'b1) begin
                    clear = 1'b1;
                    @(negedge clk_12);
                    clear = 1'b0;
                end
            end
        join
        mdl_q.delete();
        repeat (4) @(negedge clk_12);
        checks++;
        if (t >= 2000) begin errors++; $display("FAIL clear_timeout: waited %0d cycles, required < 2000", t); end
        g = pop_got();
        checks++;
        if (g !== 8'h4B) begin errors++; $display("FAIL clear_byte_presented: got %h, required 4b", g); end
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL clear_open: open=%b, required %b", open, model_open()); end
        send_ok(8'h4B);
        void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL clear_single_K: open=%b, required %b", open, model_open()); end
        send_ok(8'h4F);
        send_ok(8'h4B);
        repeat (2) void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL clear_reopen: open=%b, required %b", open, model_open()); end
    endtask

    task automatic test_random();
        logic [7:0] seq[$];
        logic [7:0] g;
        for (int i = 0; i < 8; i++) begin
            seq.delete();
            if ($urandom_range(0, 2) == 0) begin
                seq.push_back(KEY_V[15:8]);
                seq.push_back(KEY_V[7:0]);
            end else begin
                seq.push_back(8'($urandom_range(0, 255)));
            end
            foreach (seq[j]) begin
                send_ok(seq[j]);
                g = pop_got();
                checks++;
                if (g !== seq[j]) begin errors++; $display("FAIL random_byte[%0d]: got %h, required %h", i, g, seq[j]); end
                checks++;
                if (open_after !== model_open() || open !== model_open()) begin
                    errors++;
                    $display("FAIL random_open[%0d]: open=%b after=%b, required %b", i, open, open_after, model_open());
                end
            end
            repeat ($urandom_range(1, 200)) @(negedge clk_12);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        send_ok(8'h4F);
        send_ok(8'h4B);
        repeat (2) void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL rst_pre_open: open=%b, required %b", open, model_open()); end
        v0 = n_valid;
        fork
            send_frame(8'h4B, 1'b1);
            begin
                repeat (CPB * 5 + CPB / 2) @(negedge clk_12);
                rst_n = 1'b0;
                #1;
                checks++;
                if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_err !== 1'b0 || open !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_async: data=%h valid=%b err=%b open=%b, required 00/0/0/0",
                             rx_data, rx_valid, rx_err, open);
                end
            end
        join
        mdl_q.delete();
        repeat (10) @(negedge clk_12);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_12);
        checks++;
        if (n_valid != v0) begin errors++; $display("FAIL rst_aborted_frame: valids=%0d, required 0", n_valid - v0); end
        send_ok(8'h4F);
        send_ok(8'h4B);
        repeat (2) void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL rst_reopen: open=%b, required %b", open, model_open()); end
    endtask

`ifdef UART_KEY_LOCK_PARITY_EN
    task automatic test_parity();
        int e0;
        send_ok(8'h4F);
        void'(pop_got());
        e0 = n_err;
        par_flip = 1'b1;
        send_frame(8'h4B, 1'b1);
        par_flip = 1'b0;
        mdl_q.delete();
        repeat (20) @(negedge clk_12);
        checks++;
        if (n_err - e0 != 1) begin errors++; $display("FAIL parity_err: got %0d, required 1", n_err - e0); end
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL parity_open: open=%b, required %b", open, model_open()); end
        send_ok(8'h4F);
        send_ok(8'h4B);
        repeat (2) void'(pop_got());
        checks++;
        if (open !== model_open()) begin errors++; $display("FAIL parity_reopen: open=%b, required %b", open, model_open()); end
    endtask
`endif

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unlock();
        test_glitch();
        test_framing();
        test_clear();
        test_random();
`ifdef UART_KEY_LOCK_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
